// File: rtl/dbuf_rx_deglitch.sv
// Receive-side deglitcher: synchronises an asynchronous level, accepts a new level only after
// DEGLITCH_CYCLES stable samples, and reports edges plus a saturating count of rejected pulses.
module dbuf_rx_deglitch #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEGLITCH_CYCLES = 4,
  parameter int unsigned GLITCH_W        = 4,
  parameter bit          RST_VAL         = 1'b0
) (
  input  logic                CELCLK,
  input  logic                CELRSTN,
  input  logic                CELV,
  input  logic                CELG,
  input  logic                SUB,
  input  logic                i,
  input  logic                glitch_clr,
  output logic                o,
  output logic                rise,
  output logic                fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned CntW = $clog2(DEGLITCH_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEGLITCH_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StStbL, StChkH, StStbH, StChkL} state_e;

  // Power/substrate pins carry no function.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   i_sync;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   o_q, o_d;
  logic                   busy_q, busy_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [GLITCH_W-1:0]    gcnt_q, gcnt_d;
  logic                   glitch;

  assign i_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CELCLK) begin
    if (!CELRSTN) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    glitch  = 1'b0;
    unique case (state_q)
      StStbL: begin
        if (i_sync) begin
          state_d = StChkH;
          cnt_d   = CntOne;
        end
      end
      StChkH: begin
        if (!i_sync) begin
          state_d = StStbL;
          cnt_d   = '0;
          glitch  = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StStbH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStbH: begin
        if (!i_sync) begin
          state_d = StChkL;
          cnt_d   = CntOne;
        end
      end
      StChkL: begin
        if (i_sync) begin
          state_d = StStbH;
          cnt_d   = '0;
          glitch  = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StStbL;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = RST_VAL ? StStbH : StStbL;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered alongside it.
  always_comb begin
    o_d    = (state_d == StStbH) || (state_d == StChkL);
    busy_d = (state_d == StChkH) || (state_d == StChkL);
    gcnt_d = gcnt_q;
    if (glitch_clr) begin
      gcnt_d = '0;
    end else if (glitch && (gcnt_q != {GLITCH_W{1'b1}})) begin
      gcnt_d = gcnt_q + 1'b1;
    end
  end

  always_ff @(posedge CELCLK) begin
    if (!CELRSTN) begin
      state_q <= RST_VAL ? StStbH : StStbL;
      cnt_q   <= '0;
      o_q     <= RST_VAL;
      busy_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign o          = o_q;
  assign busy       = busy_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = gcnt_q;

endmodule
